// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension unit: widens an IN_W immediate to OUT_W bits
// (zero / sign / upper / byte-sign) behind a 2-entry valid/ready output buffer.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_z
);

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BYTE  = 2'b11
  } ext_mode_e;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_bsext;
  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;

  logic [OUT_W-1:0] r_mem [2];
  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;

  // Part-select overlays keep every width explicit and stay legal when OUT_W == IN_W.
  // NOTE: every variable written in always_comb is given a default first, so no path can infer a latch.
  always_comb begin
    w_zext                    = '0;
    w_zext[IN_W-1:0]          = a;
    w_sext                    = {OUT_W{a[IN_W-1]}};
    w_sext[IN_W-1:0]          = a;
    w_upper                   = '0;
    w_upper[OUT_W-1 -: IN_W]  = a;
    w_bsext                   = {OUT_W{a[7]}};
    w_bsext[7:0]              = a[7:0];
    w_ext                     = w_zext;
    case (ext_mode_e'(sel))
      EXT_ZERO:  w_ext = w_zext;
      EXT_SIGN:  w_ext = w_sext;
      EXT_UPPER: w_ext = w_upper;
      EXT_BYTE:  w_ext = w_bsext;
      default:   w_ext = w_zext;
    endcase
  end

  // Ready/valid come purely from state, so no combinational path from out_ready to in_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_z     = out_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // NOTE: the two buffer entries are reset too, so nothing stale is ever held after reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_ext;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: scoreboard fed at acceptance, drained at
// output, plus per-cycle occupancy checks and a parameter sweep.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a;
  logic [1:0]  sel;
  logic [31:0] out_z;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_a;
  logic [1:0]  b_sel;
  logic [7:0]  b_out_z;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0] c_a;
  logic [1:0]  c_sel;
  logic [63:0] c_out_z;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .a(b_a), .sel(b_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_z(b_out_z)
  );

  imm_extend_pipe #(.IN_W(16), .OUT_W(64)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .a(c_a), .sel(c_sel),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_z(c_out_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext_ref(input logic [1:0] s, input logic [15:0] v);
    case (s)
      2'b00:   return {16'h0000, v};
      2'b01:   return {{16{v[15]}}, v};
      2'b10:   return {v, 16'h0000};
      default: return {{24{v[7]}}, v[7:0]};
    endcase
  endfunction

  // Monitor at the falling edge: queue size is the modelled occupancy for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check("in_ready_vs_model", 64'(in_ready), 64'(sb_q.size() != 2));
      check("out_valid_vs_model", 64'(out_valid), 64'(sb_q.size() != 0));
      if (sb_q.size() == 0)
        check("out_z_idle_zero", 64'(out_z), 64'h0);
      if (out_valid && out_ready && sb_q.size() != 0)
        check("sb_out_z", 64'(out_z), 64'(sb_q.pop_front()));
      if (in_valid && in_ready)
        sb_q.push_back(ext_ref(sel, a));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  mode_sel [5];
  logic [15:0] mode_a   [5];
  logic [31:0] mode_exp [5];

  initial begin
    mode_sel = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
    mode_a   = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h1234, 16'h1280};
    mode_exp = '{32'hFFFFFFFF, 32'h00000001, 32'h0000FFFF, 32'h12340000, 32'hFFFFFF80};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; sel = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_a = '0; b_sel = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_a = '0; c_sel = '0; c_out_ready = 1'b1;

    #2;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_z", 64'(out_z), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_b_in_ready", 64'(b_in_ready), 64'h1);
    check("rst_c_out_valid", 64'(c_out_valid), 64'h0);
    #10 rst_n = 1'b1;

    // Extension modes, one request at a time, result visible right after acceptance.
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sel = mode_sel[i]; a = mode_a[i];
      tick();
      in_valid = 1'b0; sel = 2'b00; a = 16'h5A5A;
      check("mode_latency_valid", 64'(out_valid), 64'h1);
      check("mode_value", 64'(out_z), 64'(mode_exp[i]));
      tick();
      check("mode_drained", 64'(out_valid), 64'h0);
    end

    // Backpressure: fill both entries, third request held, then drain with simultaneous pop.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'b01; a = 16'hAAAA;
    tick();
    check("bp_first_in_ready", 64'(in_ready), 64'h1);
    sel = 2'b00; a = 16'h78D6;
    tick();
    check("bp_full_in_ready", 64'(in_ready), 64'h0);
    sel = 2'b01; a = 16'h0001;
    tick();
    check("bp_held_in_ready", 64'(in_ready), 64'h0);
    check("bp_head", 64'(out_z), 64'hFFFFAAAA);
    out_ready = 1'b1;
    tick();
    check("full_pop_in_ready", 64'(in_ready), 64'h1);
    check("full_pop_head", 64'(out_z), 64'h000078D6);
    tick();
    in_valid = 1'b0; a = 16'h0;
    check("held_accepted", 64'(out_z), 64'h00000001);
    check("held_valid", 64'(out_valid), 64'h1);
    tick();
    check("bp_empty", 64'(out_valid), 64'h0);

    // Streaming: back-to-back requests with out_ready high.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; sel = 2'b01; a = 16'(i);
      tick();
      check("stream_in_ready", 64'(in_ready), 64'h1);
      check("stream_valid", 64'(out_valid), 64'h1);
      check("stream_value", 64'(out_z), 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end", 64'(out_valid), 64'h0);

    // Asynchronous reset with two results buffered.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'b00; a = 16'h1111;
    tick();
    a = 16'h2222;
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", 64'(in_ready), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_z", 64'(out_z), 64'h0);
    check("async_rst_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_valid", 64'(out_valid), 64'h0);
      check("no_stale_z", 64'(out_z), 64'h0);
    end

    // Parameter sweep on the alternate instances.
    b_in_valid = 1'b1; b_sel = 2'b10; b_a = 8'h9C;
    c_in_valid = 1'b1; c_sel = 2'b01; c_a = 16'h8000;
    tick();
    b_in_valid = 1'b0; c_in_valid = 1'b0;
    check("sweep_8_8_valid", 64'(b_out_valid), 64'h1);
    check("sweep_8_8_value", 64'(b_out_z), 64'h9C);
    check("sweep_16_64_valid", 64'(c_out_valid), 64'h1);
    check("sweep_16_64_value", c_out_z, 64'hFFFFFFFFFFFF8000);
    tick();
    check("sweep_drained", 64'(c_out_valid), 64'h0);

    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
